// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: beam counters, registered sync/enable/strobes,
// an animation frame counter and a PIPE_DLY-deep delayed copy of sync/enable.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int PIPE_DLY  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       speed,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       vblank,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame,
    output logic       hsync_p,
    output logic       vsync_p,
    output logic       de_p
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be in 0..4");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_DISP   = 11'(H_DISPLAY);
    localparam logic [10:0] V_DISP   = 11'(V_DISPLAY);
    localparam logic [10:0] HS_FIRST = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_LAST  = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_LAST  = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic        ACT      = 1'(SYNC_POL);

    logic       h_wrap, v_wrap;
    logic [9:0] h_nxt, v_nxt;
    logic [10:0] hx, vx;

    always_comb begin
        h_wrap = (hpos == H_LAST);
        v_wrap = (vpos == V_LAST);
        h_nxt  = h_wrap ? 10'd0 : hpos + 10'd1;
        v_nxt  = vpos;
        if (h_wrap) v_nxt = v_wrap ? 10'd0 : vpos + 10'd1;
        hx = {1'b0, h_nxt};
        vx = {1'b0, v_nxt};
    end

    // Status flags are decoded from the next position so they land on the
    // same edge as the counters they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            hsync       <= ~ACT;
            vsync       <= ~ACT;
            display_on  <= 1'b1;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame       <= '0;
        end else begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= (hx >= HS_FIRST && hx <= HS_LAST) ? ACT : ~ACT;
            vsync       <= (vx >= VS_FIRST && vx <= VS_LAST) ? ACT : ~ACT;
            display_on  <= (hx < H_DISP) && (vx < V_DISP);
            vblank      <= (vx >= V_DISP);
            line_start  <= (h_nxt == 10'd0);
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
            if (h_wrap && v_wrap)
                frame <= frame + (speed ? 10'd2 : 10'd1);
        end
    end

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign {hsync_p, vsync_p, de_p} = {hsync, vsync, display_on};
        end else begin : g_dly
            // Each stage holds {hsync, vsync, de}; stage PIPE_DLY-1 is the output.
            logic [PIPE_DLY-1:0][2:0] dly;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dly <= {PIPE_DLY{~ACT, ~ACT, 1'b0}};
                end else begin
                    dly[0] <= {hsync, vsync, display_on};
                    for (int i = 1; i < PIPE_DLY; i++) dly[i] <= dly[i-1];
                end
            end
            assign {hsync_p, vsync_p, de_p} = dly[PIPE_DLY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster; expected values come from the
// elapsed cycle count since reset release (position = t mod line/frame lengths).
module tb_vga_timing_gen;
    localparam int HD = 5, HF = 2, HS = 3, HB = 2;
    localparam int VD = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;   // 12
    localparam int VT = VD + VF + VS + VB;   // 8
    localparam int FT = HT * VT;             // 96 cycles per frame
    localparam int SP = 0;
    localparam int DLY = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       speed = 1'b0;
    logic [9:0] hpos, vpos, frame;
    logic       hsync, vsync, display_on, vblank, line_start, frame_start;
    logic       hsync_p, vsync_p, de_p;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(SP), .PIPE_DLY(DLY)
    ) dut (
        .clk(clk), .reset(reset), .speed(speed),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .vblank(vblank),
        .line_start(line_start), .frame_start(frame_start), .frame(frame),
        .hsync_p(hsync_p), .vsync_p(vsync_p), .de_p(de_p)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;   // clock edges since reset release
    int frame_m = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, obs, exp);
        end
    endtask

    // Negative time means "before release": the value held by reset.
    function automatic int m_h(input int tt); return tt % HT; endfunction
    function automatic int m_v(input int tt); return (tt / HT) % VT; endfunction
    function automatic int m_hs(input int tt);
        if (tt < 0) return 1 - SP;
        return (m_h(tt) >= HD + HF && m_h(tt) < HD + HF + HS) ? SP : 1 - SP;
    endfunction
    function automatic int m_vs(input int tt);
        if (tt < 0) return 1 - SP;
        return (m_v(tt) >= VD + VF && m_v(tt) < VD + VF + VS) ? SP : 1 - SP;
    endfunction
    function automatic int m_de(input int tt);
        if (tt < 0) return 0;
        return (m_h(tt) < HD && m_v(tt) < VD) ? 1 : 0;
    endfunction

    task automatic check_all();
        chk("hpos", hpos, m_h(t));
        chk("vpos", vpos, m_v(t));
        chk("hsync", hsync, m_hs(t));
        chk("vsync", vsync, m_vs(t));
        chk("display_on", display_on, m_de(t));
        chk("vblank", vblank, (m_v(t) >= VD) ? 1 : 0);
        chk("line_start", line_start, (t > 0 && m_h(t) == 0) ? 1 : 0);
        chk("frame_start", frame_start, (t > 0 && t % FT == 0) ? 1 : 0);
        chk("frame", frame, frame_m);
        chk("hsync_p", hsync_p, m_hs(t - DLY));
        chk("vsync_p", vsync_p, m_vs(t - DLY));
        chk("de_p", de_p, m_de(t - DLY));
    endtask

    // One clock; the model advances on the same edge. full=0 checks only at wraps.
    task automatic step(input bit full);
        int inc;
        inc = speed ? 2 : 1;
        @(posedge clk);
        t++;
        if (t % FT == 0) frame_m = (frame_m + inc) % 1024;
        #1;
        if (full) check_all();
        else if (t % FT == 0) begin
            chk("wrap_frame", frame, frame_m);
            chk("wrap_frame_start", frame_start, 1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all();                       // held in reset
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();                       // released, no edge yet

        // Random speed toggles across three frames.
        for (int i = 0; i < 3 * FT; i++) begin
            step(1'b1);
            if ($urandom_range(0, 15) == 0) speed = ~speed;
        end

        // speed held high: frame advances by 2 per frame.
        speed = 1'b1;
        for (int i = 0; i < 3 * FT; i++) step(1'b1);

        // Drop speed mid-frame: next increment must be +1.
        for (int i = 0; i < FT / 2; i++) step(1'b1);
        speed = 1'b0;
        for (int i = 0; i < FT; i++) step(1'b1);

        // Preload frame to 1023, then wrap with speed=1 to land on 1.
        while (frame_m != 1023) begin
            speed = ((1023 - frame_m) >= 2);
            for (int i = 0; i < FT; i++) step(1'b0);
        end
        speed = 1'b1;
        for (int i = 0; i < FT; i++) step(1'b1);
        chk("frame_1023_plus_2", frame, 1);

        // Asynchronous reset mid-frame, between edges.
        for (int i = 0; i < FT && !(m_h(t) == 7 && m_v(t) == 5); i++) step(1'b1);
        #2;
        reset = 1'b1;
        #1;
        t = 0;
        frame_m = 0;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();
        step(1'b1);
        chk("hpos_after_release", hpos, 1);
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b1);
            if ($urandom_range(0, 7) == 0) speed = ~speed;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
